// File: rtl/cpu_pkg.sv
// Shared types and sizes for the fetch stage and its neighbours.
package cpu_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int QDEPTH     = 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory port and core-side instruction handshake.
interface instr_fetch_if;
    logic                           imem_en;
    logic [cpu_pkg::ADDR_WIDTH-1:0] imem_addr;
    logic [cpu_pkg::DATA_WIDTH-1:0] imem_rdata;
    logic                           instr_valid;
    logic                           instr_ready;
    logic [cpu_pkg::DATA_WIDTH-1:0] instr_out;
    logic [cpu_pkg::ADDR_WIDTH-1:0] instr_pc;

    // Fetch stage side
    modport master (
        output imem_en, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_rdata, instr_ready
    );

    // Memory + core side
    modport slave (
        input  imem_en, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fetch entries; head is shown combinationally.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = QDEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic            do_pop;

    // A pop against an empty queue is simply dropped.
    assign do_pop = pop && (count != '0);
    assign head   = (count != '0) ? mem[head_ptr] : '0;

    // Pointer / occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push)   tail_ptr <= tail_ptr + 1'b1;
            if (do_pop) head_ptr <= head_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[tail_ptr] <= din;
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, fetch FSM, issue credit, in-flight tracking, prefetch queue.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt,
    instr_fetch_if.master         bus,
    output logic [ADDR_WIDTH-1:0] PC_out
);
    localparam int CW = $clog2(QDEPTH);

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic [CW:0]           count;
    logic                  pop, issue, redirect, push;
    logic [CW+1:0]         occupancy;
    fetch_entry_t          head, din;

    assign pop       = bus.instr_valid & bus.instr_ready;
    assign redirect  = branch_valid && (state != IDLE);
    // Slots already spoken for: queued + returning - leaving this cycle.
    assign occupancy = {1'b0, count} + (CW+2)'(inflight) - (CW+2)'(pop);
    assign issue     = (state == FETCH) && !halt && !branch_valid &&
                       (occupancy < (CW+2)'(QDEPTH));
    assign push      = inflight && !redirect;
    assign din       = '{instr: bus.imem_rdata, pc: inflight_pc};

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_out   = head.instr;
    assign bus.instr_pc    = head.pc;
    assign PC_out          = pc;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: leave IDLE once, then follow halt.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (halt)  state_next = HALTED;
            HALTED:  if (!halt) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // PC and in-flight tag; a redirect kills the pending response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= branch_target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a 1-cycle ROM with mem[i]=0x1000+i.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  branch_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] branch_target = '0;
    logic                  halt = 1'b0;
    logic [ADDR_WIDTH-1:0] PC_out;
    logic [DATA_WIDTH-1:0] rom [32];
    int                    tests = 0;
    int                    fails = 0;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clock         (clock),
        .reset         (reset),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .bus           (bus),
        .PC_out        (PC_out)
    );

    always #5 clock = ~clock;

    // Synchronous ROM, one cycle read latency.
    always @(posedge clock) begin
        if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        branch_valid = 1'b0;
        halt = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_ready = 1'b1;
        reset = 1'b1;
        step();
        tests++;
        if ({PC_out, bus.imem_en, bus.imem_addr, bus.instr_valid, bus.instr_out, bus.instr_pc} !== '0) begin
            fails++;
            $display("FAIL reset_vals got pc=%0d en=%b addr=%0d v=%b out=%h ipc=%0d want all 0",
                     PC_out, bus.imem_en, bus.imem_addr, bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
        apply_reset();
        step();
        tests++;
        if ({bus.imem_en, bus.imem_addr, bus.instr_valid} !== {1'b1, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL cycle1 got en=%b addr=%0d v=%b want en=1 addr=0 v=0", bus.imem_en, bus.imem_addr, bus.instr_valid);
        end
        step();
        tests++;
        if (bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL cycle2_valid got %b want 0", bus.instr_valid);
        end
        step();
        tests++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h1000, 5'd0}) begin
            fails++;
            $display("FAIL cycle3 got v=%b out=%h pc=%0d want v=1 out=1000 pc=0", bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
        for (int i = 1; i < 6; i++) begin
            step();
            tests++;
            if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'(16'h1000 + i), 5'(i)}) begin
                fails++;
                $display("FAIL stream[%0d] got v=%b out=%h pc=%0d want v=1 out=%h pc=%0d",
                         i, bus.instr_valid, bus.instr_out, bus.instr_pc, 16'(16'h1000 + i), i);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.instr_ready = 1'b0;
        apply_reset();
        step(); step(); step();
        for (int c = 3; c < 5; c++) begin
            tests++;
            if ({bus.instr_valid, bus.instr_out, bus.imem_en, PC_out} !== {1'b1, 16'h1000, 1'b0, 5'd2}) begin
                fails++;
                $display("FAIL bp_hold c%0d got v=%b out=%h en=%b pcout=%0d want v=1 out=1000 en=0 pcout=2",
                         c, bus.instr_valid, bus.instr_out, bus.imem_en, PC_out);
            end
            if (c < 4) step();
        end
        bus.instr_ready = 1'b1;
        #1;
        tests++;
        if ({bus.imem_en, bus.imem_addr} !== {1'b1, 5'd2}) begin
            fails++;
            $display("FAIL bp_reissue got en=%b addr=%0d want en=1 addr=2", bus.imem_en, bus.imem_addr);
        end
        for (int i = 1; i < 3; i++) begin
            step();
            tests++;
            if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'(16'h1000 + i), 5'(i)}) begin
                fails++;
                $display("FAIL bp_drain[%0d] got v=%b out=%h pc=%0d want v=1 out=%h pc=%0d",
                         i, bus.instr_valid, bus.instr_out, bus.instr_pc, 16'(16'h1000 + i), i);
            end
        end
    endtask

    task automatic test_wrap();
        bus.instr_ready = 1'b1;
        apply_reset();
        step(); step(); step();
        // Cycle 3+n presents pc n; cycles 34..36 span the 31->0 wrap.
        for (int n = 0; n < 34; n++) begin
            tests++;
            if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'(16'h1000 + (n % 32)), 5'(n % 32)}) begin
                fails++;
                $display("FAIL wrap[%0d] got v=%b out=%h pc=%0d want v=1 out=%h pc=%0d",
                         n, bus.instr_valid, bus.instr_out, bus.instr_pc, 16'(16'h1000 + (n % 32)), n % 32);
            end
            step();
        end
    endtask

    task automatic test_branch();
        bus.instr_ready = 1'b0;
        apply_reset();
        step(); step(); step();
        // Cycle 3: one entry queued, one response in flight.
        branch_valid = 1'b1;
        branch_target = 5'd20;
        bus.instr_ready = 1'b1;
        #1;
        tests++;
        if (bus.imem_en !== 1'b0) begin
            fails++;
            $display("FAIL br_noissue got en=%b want 0", bus.imem_en);
        end
        step();
        branch_valid = 1'b0;
        #1;
        tests++;
        if ({bus.instr_valid, bus.instr_out, bus.imem_en, bus.imem_addr, PC_out} !== {1'b0, 16'h0, 1'b1, 5'd20, 5'd20}) begin
            fails++;
            $display("FAIL br_n1 got v=%b out=%h en=%b addr=%0d pcout=%0d want v=0 out=0 en=1 addr=20 pcout=20",
                     bus.instr_valid, bus.instr_out, bus.imem_en, bus.imem_addr, PC_out);
        end
        step();
        tests++;
        if (bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL br_n2 got v=%b want 0", bus.instr_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'(16'h1014 + i), 5'(20 + i)}) begin
                fails++;
                $display("FAIL br_target[%0d] got v=%b out=%h pc=%0d want v=1 out=%h pc=%0d",
                         i, bus.instr_valid, bus.instr_out, bus.instr_pc, 16'(16'h1014 + i), 20 + i);
            end
        end
    endtask

    task automatic test_halt();
        logic [21:0] exp_q [5];
        exp_q = '{ {1'b1, 16'h1002, 5'd2}, {1'b1, 16'h1003, 5'd3}, 22'd0, 22'd0, 22'd0 };
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 5; i++) step();
        // Cycles 5..9 with halt high.
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if ({bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_en, PC_out} !== {exp_q[i], 1'b0, 5'd4}) begin
                fails++;
                $display("FAIL halt[%0d] got v=%b out=%h pc=%0d en=%b pcout=%0d want %h en=0 pcout=4",
                         i, bus.instr_valid, bus.instr_out, bus.instr_pc, bus.imem_en, PC_out, exp_q[i]);
            end
            step();
        end
        halt = 1'b0;
        #1;
        tests++;
        if (bus.imem_en !== 1'b0) begin
            fails++;
            $display("FAIL halt_fall got en=%b want 0", bus.imem_en);
        end
        step();
        tests++;
        if ({bus.imem_en, bus.imem_addr} !== {1'b1, 5'd4}) begin
            fails++;
            $display("FAIL halt_resume got en=%b addr=%0d want en=1 addr=4", bus.imem_en, bus.imem_addr);
        end
        step(); step();
        tests++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h1004, 5'd4}) begin
            fails++;
            $display("FAIL halt_first got v=%b out=%h pc=%0d want v=1 out=1004 pc=4", bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
    endtask

    task automatic test_async_reset();
        bus.instr_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) step();
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({PC_out, bus.imem_en, bus.imem_addr, bus.instr_valid, bus.instr_out, bus.instr_pc} !== '0) begin
            fails++;
            $display("FAIL async_reset got pc=%0d en=%b addr=%0d v=%b out=%h ipc=%0d want all 0",
                     PC_out, bus.imem_en, bus.imem_addr, bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
        apply_reset();
        step();
        tests++;
        if ({bus.imem_en, bus.imem_addr} !== {1'b1, 5'd0}) begin
            fails++;
            $display("FAIL ar_cycle1 got en=%b addr=%0d want en=1 addr=0", bus.imem_en, bus.imem_addr);
        end
        step();
        tests++;
        if (bus.instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL ar_cycle2 got v=%b want 0", bus.instr_valid);
        end
        step();
        tests++;
        if ({bus.instr_valid, bus.instr_out, bus.instr_pc} !== {1'b1, 16'h1000, 5'd0}) begin
            fails++;
            $display("FAIL ar_cycle3 got v=%b out=%h pc=%0d want v=1 out=1000 pc=0", bus.instr_valid, bus.instr_out, bus.instr_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'(16'h1000 + i);
        bus.instr_ready = 1'b1;
        test_reset();
        test_backpressure();
        test_wrap();
        test_branch();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
